// File: rtl/fan_speed_sequencer.sv
// Fan/motor drive sequencer: maps the 2-bit speed code to a target duty,
// kick-starts from OFF at full duty, ramps duty in fixed steps and drives
// a registered, period-synchronous PWM output.
module fan_speed_sequencer #(
   parameter int PWM_DIV      = 4,
   parameter int RAMP_TICKS   = 64,
   parameter int KICK_PERIODS = 16,
   parameter int STEP         = 5,
   parameter int DUTY_SLOW    = 85,
   parameter int DUTY_MED     = 170,
   parameter int DUTY_FAST    = 255
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic [1:0] speed_select,
   output logic       pwm_out,
   output logic [7:0] duty,
   output logic       busy,
   output logic       at_speed
);

   localparam int DIV_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
   localparam int TICK_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
   localparam int KICK_W = (KICK_PERIODS > 0) ? $clog2(KICK_PERIODS + 1) : 1;

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(PWM_DIV - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RAMP_TICKS - 1);
   localparam logic [KICK_W-1:0] KICK_LAST = KICK_W'((KICK_PERIODS > 0) ? KICK_PERIODS - 1 : 0);
   localparam logic [7:0]        STEP8     = 8'(STEP);
   localparam logic [8:0]        STEP9     = 9'(STEP);
   localparam logic [7:0]        SLOW8     = 8'(DUTY_SLOW);
   localparam logic [7:0]        MED8      = 8'(DUTY_MED);
   localparam logic [7:0]        FAST8     = 8'(DUTY_FAST);

   typedef enum logic [1:0] {S_IDLE, S_KICK, S_RAMP, S_HOLD} state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [7:0]         applied_q, applied_d;
   logic               pwm_q, pwm_d;
   logic [7:0]         duty_q, duty_d;
   logic [KICK_W-1:0]  kick_q, kick_d;
   logic [TICK_W-1:0]  tick_q, tick_d;

   logic [7:0] target;
   logic       inc_en;
   logic       boundary;
   logic       ramp_tick;
   logic [8:0] up_sum;
   logic [8:0] dn_lim;
   logic [7:0] stepped;
   logic [7:0] kick_exit_duty;

   // Decode the speed code into the target duty.
   always_comb begin
      case (speed_select)
         2'd1:    target = SLOW8;
         2'd2:    target = MED8;
         2'd3:    target = FAST8;
         default: target = 8'd0;
      endcase
   end

   assign inc_en    = (div_q == DIV_LAST);
   assign boundary  = inc_en && (cnt_q == 8'hFF);
   assign ramp_tick = (state_q == S_RAMP) && boundary && (tick_q == TICK_LAST);

   // PWM prescaler/counter; duty is latched only at the period boundary, but
   // a disable zeroes the applied duty at once so the pin drops immediately.
   always_comb begin
      div_d     = inc_en ? '0 : div_q + DIV_W'(1);
      cnt_d     = inc_en ? cnt_q + 8'd1 : cnt_q;
      applied_d = applied_q;
      if (!enable) begin
         applied_d = '0;
      end else if (boundary) begin
         applied_d = duty_q;
      end
      pwm_d = enable && (cnt_q < applied_q);
   end

   // Ramp tick divider: counts period boundaries only while ramping, so it
   // restarts from zero on every entry to RAMP.
   always_comb begin
      tick_d = '0;
      if (state_q == S_RAMP) begin
         if (boundary) begin
            tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
         end else begin
            tick_d = tick_q;
         end
      end
   end

   // Saturating one-step move toward the target (9-bit math, no wrap).
   always_comb begin
      up_sum         = {1'b0, duty_q} + STEP9;
      dn_lim         = {1'b0, target} + STEP9;
      kick_exit_duty = (SLOW8 < target) ? SLOW8 : target;
      if (duty_q < target) begin
         stepped = (up_sum >= {1'b0, target}) ? target : up_sum[7:0];
      end else begin
         stepped = (dn_lim >= {1'b0, duty_q}) ? target : duty_q - STEP8;
      end
   end

   // Sequencer next-state and duty logic; disable overrides everything.
   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      kick_d  = kick_q;
      if (!enable) begin
         state_d = S_IDLE;
         duty_d  = '0;
         kick_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               duty_d = '0;
               kick_d = '0;
               if (target != 8'd0) begin
                  if (KICK_PERIODS > 0) begin
                     state_d = S_KICK;
                     duty_d  = 8'hFF;
                  end else begin
                     state_d = S_RAMP;
                  end
               end
            end
            S_KICK: begin
               if (target == 8'd0) begin
                  state_d = S_RAMP;
               end else if (boundary) begin
                  if (kick_q == KICK_LAST) begin
                     state_d = S_RAMP;
                     duty_d  = kick_exit_duty;
                     kick_d  = '0;
                  end else begin
                     kick_d = kick_q + KICK_W'(1);
                  end
               end
            end
            S_RAMP: begin
               if (duty_q == target) begin
                  state_d = (target != 8'd0) ? S_HOLD : S_IDLE;
               end else if (ramp_tick) begin
                  duty_d = stepped;
               end
            end
            S_HOLD: begin
               if (duty_q != target) begin
                  state_d = S_RAMP;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         div_q     <= '0;
         cnt_q     <= '0;
         applied_q <= '0;
         pwm_q     <= 1'b0;
         duty_q    <= '0;
         kick_q    <= '0;
         tick_q    <= '0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         cnt_q     <= cnt_d;
         applied_q <= applied_d;
         pwm_q     <= pwm_d;
         duty_q    <= duty_d;
         kick_q    <= kick_d;
         tick_q    <= tick_d;
      end
   end

   assign pwm_out  = pwm_q;
   assign duty     = duty_q;
   assign busy     = (state_q == S_KICK) || (state_q == S_RAMP);
   assign at_speed = (state_q == S_HOLD);

endmodule

// File: tb/tb_fan_speed_sequencer.sv
// Bench for fan_speed_sequencer: two instances (kick/STEP=85 and
// no-kick/STEP=100), a behavioural reference model checked every cycle,
// and directed scenarios with hand-computed expectations.
module tb_fan_speed_sequencer;

   localparam int RT  = 2;
   localparam int KP0 = 2;
   localparam int ST0 = 85;
   localparam int KP1 = 0;
   localparam int ST1 = 100;

   localparam int M_OFF  = 0;
   localparam int M_KICK = 1;
   localparam int M_RAMP = 2;
   localparam int M_HOLD = 3;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       en0, en1;
   logic [1:0] sel0, sel1;
   logic       pwm0, pwm1, busy0, busy1, at0, at1;
   logic [7:0] duty0, duty1;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_on  = 1'b0;
   int max_seen = 0;

   always #5 clk = ~clk;

   fan_speed_sequencer #(
      .PWM_DIV(1), .RAMP_TICKS(RT), .KICK_PERIODS(KP0), .STEP(ST0),
      .DUTY_SLOW(85), .DUTY_MED(170), .DUTY_FAST(255)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(en0), .speed_select(sel0),
      .pwm_out(pwm0), .duty(duty0), .busy(busy0), .at_speed(at0)
   );

   fan_speed_sequencer #(
      .PWM_DIV(1), .RAMP_TICKS(RT), .KICK_PERIODS(KP1), .STEP(ST1),
      .DUTY_SLOW(85), .DUTY_MED(170), .DUTY_FAST(255)
   ) dut_sat (
      .clk(clk), .reset_n(reset_n), .enable(en1), .speed_select(sel1),
      .pwm_out(pwm1), .duty(duty1), .busy(busy1), .at_speed(at1)
   );

   // ---------------- reference model ----------------
   int m_cnt[2];
   int m_applied[2];
   int m_duty[2];
   int m_mode[2];
   int m_kick[2];
   int m_ticks[2];
   int m_pwm[2];

   function automatic int tgt_of(input logic [1:0] c);
      case (c)
         2'd1:    return 85;
         2'd2:    return 170;
         2'd3:    return 255;
         default: return 0;
      endcase
   endfunction

   function automatic int toward(input int d, input int t, input int s);
      if (d < t) return (d + s > t) ? t : d + s;
      return (d - s < t) ? t : d - s;
   endfunction

   always @(posedge clk or negedge reset_n) begin : model
      bit en;
      int tg;
      int kp;
      int st;
      bit bnd;
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_applied[i] = 0; m_duty[i] = 0; m_mode[i] = M_OFF;
            m_kick[i] = 0; m_ticks[i] = 0; m_pwm[i] = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            en  = (i == 0) ? en0 : en1;
            tg  = tgt_of((i == 0) ? sel0 : sel1);
            kp  = (i == 0) ? KP0 : KP1;
            st  = (i == 0) ? ST0 : ST1;
            bnd = (m_cnt[i] == 255);
            m_pwm[i] = (en && (m_cnt[i] < m_applied[i])) ? 1 : 0;
            if (!en) m_applied[i] = 0;
            else if (bnd) m_applied[i] = m_duty[i];
            if (!en) begin
               m_mode[i] = M_OFF;
               m_duty[i] = 0;
            end else begin
               case (m_mode[i])
                  M_OFF: begin
                     if (tg != 0) begin
                        if (kp > 0) begin
                           m_mode[i] = M_KICK; m_duty[i] = 255; m_kick[i] = 0;
                        end else begin
                           m_mode[i] = M_RAMP; m_ticks[i] = 0;
                        end
                     end
                  end
                  M_KICK: begin
                     if (tg == 0) begin
                        m_mode[i] = M_RAMP; m_ticks[i] = 0;
                     end else if (bnd) begin
                        m_kick[i]++;
                        if (m_kick[i] == kp) begin
                           m_duty[i]  = (tg < 85) ? tg : 85;
                           m_mode[i]  = M_RAMP;
                           m_ticks[i] = 0;
                        end
                     end
                  end
                  M_RAMP: begin
                     if (m_duty[i] == tg) begin
                        m_mode[i] = (tg != 0) ? M_HOLD : M_OFF;
                     end else if (bnd) begin
                        m_ticks[i]++;
                        if (m_ticks[i] % RT == 0) m_duty[i] = toward(m_duty[i], tg, st);
                     end
                  end
                  default: begin
                     if (tg != m_duty[i]) begin
                        m_mode[i] = M_RAMP; m_ticks[i] = 0;
                     end
                  end
               endcase
            end
            m_cnt[i] = (m_cnt[i] + 1) % 256;
         end
      end
   end

   task automatic check(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         check("m0.duty", int'(duty0), m_duty[0]);
         check("m0.pwm", int'(pwm0), m_pwm[0]);
         check("m0.busy", int'(busy0), (m_mode[0] == M_KICK || m_mode[0] == M_RAMP) ? 1 : 0);
         check("m0.at_speed", int'(at0), (m_mode[0] == M_HOLD) ? 1 : 0);
         check("m1.duty", int'(duty1), m_duty[1]);
         check("m1.pwm", int'(pwm1), m_pwm[1]);
         check("m1.busy", int'(busy1), (m_mode[1] == M_KICK || m_mode[1] == M_RAMP) ? 1 : 0);
         check("m1.at_speed", int'(at1), (m_mode[1] == M_HOLD) ? 1 : 0);
      end
   end

   // Wait until an instance's duty reaches val; returns elapsed clocks.
   task automatic wait_duty(input int inst, input int val, input int bound,
                            input string nm, output int cyc);
      int d;
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         d = (inst == 0) ? int'(duty0) : int'(duty1);
         if (d > max_seen) max_seen = d;
         if (d == val) break;
         if (cyc >= bound) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout %s: duty=%0d required %0d within %0d clocks", nm, d, val, bound);
            break;
         end
      end
   endtask

   // Stop at the clock just before a PWM period boundary.
   task automatic align();
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (m_cnt[0] == 255) return;
      end
      n_tests++;
      n_fail++;
      $display("FAIL timeout align: no period boundary within 300 clocks");
   endtask

   initial begin : stim
      int c;
      int hi;
      reset_n = 1'b1;
      en0 = 1'b0; en1 = 1'b0; sel0 = 2'd0; sel1 = 2'd0;
      #1 reset_n = 1'b0;
      chk_on = 1'b1;
      repeat (3) @(negedge clk);
      $display("[TB] reset state");
      check("rst_duty", int'(duty0), 0);
      check("rst_busy", int'(busy0), 0);
      check("rst_at_speed", int'(at0), 0);
      check("rst_pwm", int'(pwm0), 0);
      reset_n = 1'b1;
      en0 = 1'b1; en1 = 1'b1;
      repeat (10) @(negedge clk);
      check("idle_busy", int'(busy0), 0);
      check("idle_duty", int'(duty0), 0);

      $display("[TB] start from OFF, code 11");
      align();
      sel0 = 2'd3;
      wait_duty(0, 255, 4, "kick_on", c);   check("kick_on_latency", c, 1);
      wait_duty(0, 85, 600, "kick_end", c); check("kick_len", c, 512);
      wait_duty(0, 170, 600, "ramp_170", c); check("ramp_170_gap", c, 512);
      wait_duty(0, 255, 600, "ramp_255", c); check("ramp_255_gap", c, 512);
      @(negedge clk);
      check("hold_at_speed", int'(at0), 1);
      check("hold_busy", int'(busy0), 0);
      repeat (300) @(negedge clk);
      hi = 0;
      repeat (256) begin
         @(negedge clk);
         hi += int'(pwm0);
      end
      check("pwm_high_of_256", hi, 255);

      $display("[TB] soft stop from 170");
      sel0 = 2'd2;
      wait_duty(0, 170, 1200, "down_170", c);
      @(negedge clk);
      check("hold170_at_speed", int'(at0), 1);
      sel0 = 2'd0;
      wait_duty(0, 85, 1200, "stop_85", c);
      wait_duty(0, 0, 600, "stop_0", c); check("stop_step_gap", c, 512);
      @(negedge clk);
      check("stop_busy", int'(busy0), 0);
      repeat (300) @(negedge clk);
      hi = 0;
      repeat (300) begin
         @(negedge clk);
         hi += int'(pwm0);
      end
      check("stop_pwm_low", hi, 0);

      $display("[TB] mid-ramp retarget to 01");
      sel0 = 2'd3;
      wait_duty(0, 85, 1200, "rt_85", c);
      wait_duty(0, 170, 600, "rt_170", c);
      max_seen = 0;
      sel0 = 2'd1;
      wait_duty(0, 85, 600, "rt_back", c); check("retarget_gap", c, 512);
      check("retarget_max", max_seen, 170);
      @(negedge clk);
      check("retarget_at_speed", int'(at0), 1);

      $display("[TB] enable drop during kick");
      en0 = 1'b0;
      @(negedge clk);
      check("dis_duty", int'(duty0), 0);
      sel0 = 2'd3;
      align();
      en0 = 1'b1;
      wait_duty(0, 255, 4, "kick2_on", c); check("kick2_on_latency", c, 1);
      repeat (300) @(negedge clk);
      check("kick2_pwm_high", int'(pwm0), 1);
      check("kick2_busy", int'(busy0), 1);
      en0 = 1'b0;
      @(negedge clk);
      check("drop_pwm", int'(pwm0), 0);
      check("drop_duty", int'(duty0), 0);
      check("drop_busy", int'(busy0), 0);
      align();
      en0 = 1'b1;
      wait_duty(0, 255, 4, "kick3_on", c);   check("kick3_on_latency", c, 1);
      wait_duty(0, 85, 600, "kick3_end", c); check("kick3_len", c, 512);

      $display("[TB] saturation, STEP=100 no kick");
      max_seen = 0;
      sel1 = 2'd2;
      wait_duty(1, 100, 1200, "sat_100", c);
      wait_duty(1, 170, 600, "sat_170", c); check("sat_gap", c, 512);
      check("sat_max", max_seen, 170);
      @(negedge clk);
      check("sat_at_speed", int'(at1), 1);

      $display("[TB] async reset mid-PWM at duty 170");
      repeat (300) @(negedge clk);
      align();
      repeat (10) @(negedge clk);
      check("pre_rst_pwm", int'(pwm1), 1);
      check("pre_rst_duty", int'(duty1), 170);
      #2 reset_n = 1'b0;
      #1;
      check("arst_duty", int'(duty1), 0);
      check("arst_pwm", int'(pwm1), 0);
      check("arst_busy", int'(busy1), 0);
      check("arst_at_speed", int'(at1), 0);
      check("arst_duty0", int'(duty0), 0);
      sel0 = 2'd0; sel1 = 2'd0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      check("post_rst_busy0", int'(busy0), 0);
      check("post_rst_busy1", int'(busy1), 0);
      check("post_rst_duty1", int'(duty1), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
